// File: rtl/cart_rom_reader.sv
// -----------------------------------------------------------------------------
// cart_rom_reader
//
// Sweeps a Game Boy cartridge ROM from START_ADDR to END_ADDR (inclusive,
// wrapping through 16'hFFFF -> 16'h0000 when END_ADDR < START_ADDR).
// For each address the address bus and read strobe are held for
// SETTLE_CYCLES clocks, the data bus is captured, and {out_addr, out_data}
// is offered on a valid/ready stream.
//
// Stream handshake: a byte transfers on a rising edge where out_valid and
// out_ready are both high. Once out_valid rises, out_valid, out_data and
// out_addr stay constant until that transfer (or an abort) occurs;
// out_ready may change freely and never affects out_valid combinationally.
//
// Optional build macro: CART_ROM_CHECKSUM_EN adds the 'checksum' output,
// a running 16-bit sum of every byte transferred on the stream.
//
// Ports:
//   clock           system clock, rising edge
//   reset           synchronous, active-high reset
//   start           begin a sweep (only looked at while idle)
//   abort           stop the current sweep, back to idle on the next edge
//   cart_data[7:0]  cartridge data bus
//   cart_addr[15:0] cartridge address bus
//   cart_rd_l       cartridge read strobe, active-low
//   cart_wr_l       cartridge write strobe, tied inactive (1)
//   cart_cs_sram_l  cartridge SRAM select, tied inactive (1)
//   cart_reset_l    cartridge reset, tied inactive (1)
//   out_valid       captured byte available
//   out_ready       downstream accepts the byte
//   out_data[7:0]   captured byte
//   out_addr[15:0]  address the byte was read from
//   busy            high whenever not idle
//   done            one-cycle pulse after the last byte is accepted
//   checksum[15:0]  (CART_ROM_CHECKSUM_EN only) sum of accepted bytes
// -----------------------------------------------------------------------------
module cart_rom_reader #(
    parameter int          SETTLE_CYCLES = 8,
    parameter logic [15:0] START_ADDR    = 16'h0000,
    parameter logic [15:0] END_ADDR      = 16'h7FFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  cart_data,
    output logic [15:0] cart_addr,
    output logic        cart_rd_l,
    output logic        cart_wr_l,
    output logic        cart_cs_sram_l,
    output logic        cart_reset_l,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic [15:0] out_addr,
    output logic        busy,
    output logic        done
`ifdef CART_ROM_CHECKSUM_EN
    ,
    output logic [15:0] checksum
`endif
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        SETTLE       = 2'd1,
        CAPTURE_WAIT = 2'd2,
        DONE         = 2'd3
    } state_t;

    // Counter value on the edge that captures the data bus.
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [7:0] settle_cnt;

    // The cartridge is only ever read, never written or reset.
    assign cart_wr_l      = 1'b1;
    assign cart_cs_sram_l = 1'b1;
    assign cart_reset_l   = 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cart_addr  <= START_ADDR;
            cart_rd_l  <= 1'b1;
            out_valid  <= 1'b0;
            out_data   <= 8'h00;
            out_addr   <= 16'h0000;
            busy       <= 1'b0;
            done       <= 1'b0;
            settle_cnt <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    done      <= 1'b0;
                    cart_rd_l <= 1'b1;
                    // abort in the same cycle cancels the start request.
                    if (start && !abort) begin
                        cart_addr  <= START_ADDR;
                        cart_rd_l  <= 1'b0;
                        settle_cnt <= 8'd0;
                        busy       <= 1'b1;
                        state      <= SETTLE;
                    end
                end

                SETTLE: begin
                    if (abort) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        cart_rd_l <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b0;
                    end else begin
                        settle_cnt <= settle_cnt + 8'd1;
                        if (settle_cnt == SETTLE_LAST) begin
                            out_data  <= cart_data;
                            out_addr  <= cart_addr;
                            out_valid <= 1'b1;
                            state     <= CAPTURE_WAIT;
                        end
                    end
                end

                CAPTURE_WAIT: begin
                    // abort wins over a same-cycle transfer; that byte is lost.
                    if (abort) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        cart_rd_l <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b0;
                    end else if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        if (cart_addr == END_ADDR) begin
                            cart_rd_l <= 1'b1;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            // Natural 16-bit overflow gives the FFFF -> 0000 wrap.
                            cart_addr  <= cart_addr + 16'd1;
                            settle_cnt <= 8'd0;
                            state      <= SETTLE;
                        end
                    end
                end

                DONE: begin
                    // busy and done fall together as the sweep returns to idle.
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    cart_rd_l <= 1'b1;
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end

                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    cart_rd_l <= 1'b1;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

`ifdef CART_ROM_CHECKSUM_EN
    // Sums only bytes that actually transfer; an abort freezes the value.
    always_ff @(posedge clock) begin
        if (reset) begin
            checksum <= 16'h0000;
        end else if (state == IDLE && start && !abort) begin
            checksum <= 16'h0000;
        end else if (state == CAPTURE_WAIT && !abort && out_valid && out_ready) begin
            checksum <= checksum + {8'h00, out_data};
        end
    end
`endif

endmodule

// File: tb/tb_cart_rom_reader.sv
// -----------------------------------------------------------------------------
// tb_cart_rom_reader
//
// Three reader instances with different sweep shapes:
//   0: SETTLE=4, 0x0100..0x0103   (plain sweep, backpressure, abort, reset)
//   1: SETTLE=2, 0xFFFE..0x0001   (address wrap)
//   2: SETTLE=1, 0x1234..0x1234   (single byte)
// Each cartridge model returns addr[7:0] ^ key (or 0xFF when ff_en is set).
// The expected byte stream for a sweep is built from the address range, and
// timing is checked from the rule "first valid SETTLE cycles after start or
// after the previous transfer". Outputs are sampled on the falling edge.
// Build with +define+CART_ROM_CHECKSUM_EN to include the checksum checks.
// -----------------------------------------------------------------------------
module tb_cart_rom_reader;

    localparam logic [23:0] SETS   = {8'd1, 8'd2, 8'd4};
    localparam logic [47:0] STARTS = {16'h1234, 16'hFFFE, 16'h0100};
    localparam logic [47:0] ENDS   = {16'h1234, 16'h0001, 16'h0103};

    logic        clock;
    logic        reset;
    logic        start     [3];
    logic        abort     [3];
    logic        out_ready [3];
    logic [7:0]  cart_data [3];
    logic [15:0] cart_addr [3];
    logic        cart_rd_l [3];
    logic        cart_wr_l [3];
    logic        cart_cs_sram_l [3];
    logic        cart_reset_l   [3];
    logic        out_valid [3];
    logic [7:0]  out_data  [3];
    logic [15:0] out_addr  [3];
    logic        busy      [3];
    logic        done      [3];
`ifdef CART_ROM_CHECKSUM_EN
    logic [15:0] checksum  [3];
`endif

    logic [7:0] key;
    logic       ff_en;
    int         total;
    int         bad;

    // ---------------- clock ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- DUTs and cartridge models ----------------
    for (genvar g = 0; g < 3; g++) begin : gen_dut
        cart_rom_reader #(
            .SETTLE_CYCLES (int'(SETS[g*8 +: 8])),
            .START_ADDR    (STARTS[g*16 +: 16]),
            .END_ADDR      (ENDS[g*16 +: 16])
        ) u_dut (
            .clock          (clock),
            .reset          (reset),
            .start          (start[g]),
            .abort          (abort[g]),
            .cart_data      (cart_data[g]),
            .cart_addr      (cart_addr[g]),
            .cart_rd_l      (cart_rd_l[g]),
            .cart_wr_l      (cart_wr_l[g]),
            .cart_cs_sram_l (cart_cs_sram_l[g]),
            .cart_reset_l   (cart_reset_l[g]),
            .out_valid      (out_valid[g]),
            .out_ready      (out_ready[g]),
            .out_data       (out_data[g]),
            .out_addr       (out_addr[g]),
            .busy           (busy[g]),
            .done           (done[g])
`ifdef CART_ROM_CHECKSUM_EN
            ,
            .checksum       (checksum[g])
`endif
        );
        assign cart_data[g] = ff_en ? 8'hFF : (cart_addr[g][7:0] ^ key);
    end

    // ---------------- helpers ----------------
    function automatic logic [7:0] exp_byte(input logic [15:0] a);
        return ff_en ? 8'hFF : (a[7:0] ^ key);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input int g);
        check("rst_cart_addr", cart_addr[g], STARTS[g*16 +: 16]);
        check("rst_rd_l",      cart_rd_l[g], 1);
        check("rst_wr_l",      cart_wr_l[g], 1);
        check("rst_cs_sram_l", cart_cs_sram_l[g], 1);
        check("rst_reset_l",   cart_reset_l[g], 1);
        check("rst_out_valid", out_valid[g], 0);
        check("rst_out_data",  out_data[g], 0);
        check("rst_out_addr",  out_addr[g], 0);
        check("rst_busy",      busy[g], 0);
        check("rst_done",      done[g], 0);
`ifdef CART_ROM_CHECKSUM_EN
        check("rst_checksum",  checksum[g], 0);
`endif
    endtask

    // One full sweep on instance g. ready_pct: chance of out_ready per cycle;
    // hold_byte: index of a byte that sees 10 valid cycles of out_ready=0
    // (-1 for none); poke_start: pulse start mid-sweep (must be ignored).
    task automatic run_sweep(input int g, input int ready_pct, input int hold_byte,
                             input bit poke_start);
        logic [23:0] exp_q[$];
        logic [15:0] a;
        logic [15:0] sum;
        int settle, n, last_ev, k, hold;
        bit seen, rdy, got_done;

        settle = int'(SETS[g*8 +: 8]);
        sum = 16'h0000;
        a = STARTS[g*16 +: 16];
        while (1) begin
            exp_q.push_back({a, exp_byte(a)});
            if (a == ENDS[g*16 +: 16]) break;
            a = a + 16'd1;
        end

        @(negedge clock);
        start[g] = 1'b1;
        @(negedge clock);
        start[g] = 1'b0;
        n = 0; last_ev = 0; k = 0; hold = 0; seen = 0; got_done = 0;
        while (n < 3000) begin
            if (done[g]) begin
                got_done = 1;
                check("done_qsize", exp_q.size(), 0);
                check("done_time",  n, last_ev);
                check("done_busy",  busy[g], 1);
                check("done_rd_l",  cart_rd_l[g], 1);
                break;
            end
            check("sweep_busy", busy[g], 1);
            check("sweep_rd_l", cart_rd_l[g], 0);
            if (exp_q.size() == 0) begin
                check("overrun_qsize", exp_q.size(), 1);
                break;
            end
            check("sweep_cart_addr", cart_addr[g], exp_q[0][23:8]);
            if (out_valid[g]) begin
                if (!seen) check("valid_time", n, last_ev + settle);
                seen = 1;
                check("out_addr", out_addr[g], exp_q[0][23:8]);
                check("out_data", out_data[g], exp_q[0][7:0]);
            end
            if (k == hold_byte && hold < 10) begin
                rdy = 1'b0;
                if (out_valid[g]) hold++;
            end else begin
                rdy = ($urandom_range(99) < ready_pct);
            end
            out_ready[g] = rdy;
            start[g] = poke_start && (n == 2);
            if (out_valid[g] && rdy) begin
                sum = sum + {8'h00, exp_q[0][7:0]};
                void'(exp_q.pop_front());
                k++;
                seen = 0;
                last_ev = n + 1;
            end
            @(negedge clock);
            n++;
        end
        start[g] = 1'b0;
        out_ready[g] = 1'b0;
        check("done_seen", got_done, 1);
`ifdef CART_ROM_CHECKSUM_EN
        check("checksum_done", checksum[g], sum);
`endif
        @(negedge clock);
        check("post_done",      done[g], 0);
        check("post_busy",      busy[g], 0);
        check("post_rd_l",      cart_rd_l[g], 1);
        check("post_out_valid", out_valid[g], 0);
`ifdef CART_ROM_CHECKSUM_EN
        check("checksum_hold", checksum[g], sum);
`endif
    endtask

    task automatic wait_valid(input int g);
        for (int i = 0; i < 300 && !out_valid[g]; i++) @(negedge clock);
        check("wait_valid", out_valid[g], 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        total = 0;
        bad = 0;
        key = 8'hA5;
        ff_en = 1'b0;
        reset = 1'b1;
        for (int g = 0; g < 3; g++) begin
            start[g] = 1'b1;
            abort[g] = 1'b0;
            out_ready[g] = 1'b0;
        end

        // Reset for two cycles with start held high; it must not take effect.
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int g = 0; g < 3; g++) start[g] = 1'b0;
        for (int g = 0; g < 3; g++) check_reset_vals(g);
        @(negedge clock);
        for (int g = 0; g < 3; g++) check("idle_after_reset_busy", busy[g], 0);

        // Directed sweep: bytes A5,A4,A7,A6 at 0x0100..0x0103, ready always high.
        run_sweep(0, 100, -1, 1'b0);

        // Backpressure on the second byte.
        key = 8'($urandom);
        run_sweep(0, 100, 1, 1'b0);

        // Address wrap, then single-byte range.
        run_sweep(1, 100, -1, 1'b0);
        run_sweep(1, 60, 0, 1'b1);
        run_sweep(2, 100, -1, 1'b0);
        run_sweep(2, 50, -1, 1'b1);

        // Random sweeps across all instances.
        for (int i = 0; i < 8; i++) begin
            key = 8'($urandom);
            run_sweep(int'($urandom_range(2)), int'($urandom_range(100, 25)),
                      ($urandom_range(3) == 0) ? 1 : -1, 1'($urandom_range(1)));
        end

        // Abort during the second SETTLE: no done, then a clean restart.
        key = 8'h3C;
        @(negedge clock);
        start[0] = 1'b1;
        out_ready[0] = 1'b1;
        @(negedge clock);
        start[0] = 1'b0;
        wait_valid(0);
        check("abort_first_addr", out_addr[0], 16'h0100);
        @(negedge clock);
        @(negedge clock);
        check("abort_pre_addr", cart_addr[0], 16'h0101);
        abort[0] = 1'b1;
        @(negedge clock);
        abort[0] = 1'b0;
        out_ready[0] = 1'b0;
        check("abort_busy",      busy[0], 0);
        check("abort_out_valid", out_valid[0], 0);
        check("abort_rd_l",      cart_rd_l[0], 1);
        check("abort_done",      done[0], 0);
`ifdef CART_ROM_CHECKSUM_EN
        check("abort_checksum",  checksum[0], {8'h00, exp_byte(16'h0100)});
`endif
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check("abort_no_done", done[0], 0);
            check("abort_stay_idle", busy[0], 0);
        end
        run_sweep(0, 100, -1, 1'b0);

        // Abort together with a transfer: the byte is dropped.
        @(negedge clock);
        start[1] = 1'b1;
        @(negedge clock);
        start[1] = 1'b0;
        wait_valid(1);
        out_ready[1] = 1'b1;
        abort[1] = 1'b1;
        @(negedge clock);
        out_ready[1] = 1'b0;
        abort[1] = 1'b0;
        check("abort_hs_busy",      busy[1], 0);
        check("abort_hs_out_valid", out_valid[1], 0);
        check("abort_hs_done",      done[1], 0);
`ifdef CART_ROM_CHECKSUM_EN
        check("abort_hs_checksum",  checksum[1], 0);
`endif
        run_sweep(1, 100, -1, 1'b0);

        // start and abort together while idle: stays idle.
        @(negedge clock);
        start[2] = 1'b1;
        abort[2] = 1'b1;
        @(negedge clock);
        start[2] = 1'b0;
        abort[2] = 1'b0;
        check("start_abort_idle_busy", busy[2], 0);
        check("start_abort_idle_rd_l", cart_rd_l[2], 1);

        // All-0xFF data: four bytes sum to 0x03FC; a new start clears the sum.
        ff_en = 1'b1;
        run_sweep(0, 100, -1, 1'b0);
`ifdef CART_ROM_CHECKSUM_EN
        check("checksum_ff", checksum[0], 16'h03FC);
`endif
        @(negedge clock);
        start[0] = 1'b1;
        @(negedge clock);
        start[0] = 1'b0;
        check("restart_busy", busy[0], 1);
`ifdef CART_ROM_CHECKSUM_EN
        check("checksum_cleared", checksum[0], 0);
`endif
        ff_en = 1'b0;

        // Reset in the middle of a sweep with a byte waiting.
        wait_valid(0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_reset_vals(0);

        repeat (2) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #600000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cart_rom_reader.md
Name: cart_rom_reader

Overview:
- Sequencer that drives the Game Boy cartridge bus and sweeps ROM addresses START_ADDR..END_ADDR.
- Per address: waits a fixed settle time, samples the 8-bit cartridge data bus, then presents {address, byte} on a valid/ready stream.
- Sits between the cartridge header pins (address/control out, data in) and a downstream sink (UART or LED/debug consumer).
- Replaces switch-driven manual addressing with a full automated dump.

Parameters:
- SETTLE_CYCLES, 8: clocks address/read strobe are held before data is sampled; legal range 1..255.
- START_ADDR, 16'h0000: first address read.
- END_ADDR, 16'h7FFF: last address read, inclusive.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a sweep; sampled only in IDLE.
- abort  input  1  terminate the sweep; return to IDLE next cycle.
- cart_data  input  8  cartridge data bus D[7:0].
- cart_addr  output  16  cartridge address bus A[15:0].
- cart_rd_l  output  1  read enable, active-low.
- cart_wr_l  output  1  write enable, active-low; constant 1.
- cart_cs_sram_l  output  1  SRAM chip select, active-low; constant 1.
- cart_reset_l  output  1  cartridge reset, active-low; constant 1.
- out_valid  output  1  out_data/out_addr hold a captured byte.
- out_ready  input  1  downstream accepts the byte.
- out_data  output  8  captured byte.
- out_addr  output  16  address of the captured byte.
- busy  output  1  high in any state except IDLE.
- done  output  1  one-cycle pulse after the END_ADDR byte is accepted.

Behaviour:
- Reset values:
  - state = IDLE; cart_addr = START_ADDR; cart_rd_l = 1.
  - out_valid = 0; out_data = 0; out_addr = 0.
  - busy = 0; done = 0; settle counter = 0.
  - cart_wr_l, cart_cs_sram_l and cart_reset_l are always 1.
  - Reset mid-sweep forces these values on the next edge, regardless of other inputs.
- States: IDLE, SETTLE, CAPTURE_WAIT, DONE.
- IDLE:
  - cart_rd_l = 1.
  - start = 1 → cart_addr ← START_ADDR, cart_rd_l ← 0, counter ← 0, go to SETTLE.
- SETTLE:
  - Lasts exactly SETTLE_CYCLES cycles; counter increments each cycle.
  - On the edge where counter == SETTLE_CYCLES-1: out_data ← cart_data, out_addr ← cart_addr, out_valid ← 1, go to CAPTURE_WAIT.
- CAPTURE_WAIT:
  - out_valid, out_data and out_addr are held stable until out_valid & out_ready.
  - cart_rd_l stays 0.
  - On handshake: out_valid ← 0.
    - If cart_addr == END_ADDR: go to DONE.
    - Else: cart_addr ← cart_addr + 1 (mod 2^16), counter ← 0, go to SETTLE.
- DONE:
  - done = 1, cart_rd_l = 1, for exactly one cycle; then IDLE.
- Latency: with start sampled at edge N, out_valid is first high after edge N+SETTLE_CYCLES.
- Throughput: one byte per SETTLE_CYCLES+1 clocks when out_ready is held high.
- Address wrap: if END_ADDR < START_ADDR, the sweep wraps 16'hFFFF → 16'h0000 and stops after END_ADDR.
- START_ADDR == END_ADDR: exactly one byte is produced.
- start while busy: ignored.
- abort (any non-IDLE state): next edge → IDLE, out_valid = 0, cart_rd_l = 1, no done pulse.
- abort has priority over a same-cycle handshake; that byte counts as dropped.
- abort and start together in IDLE: start is ignored.
- cart_data is sampled only on the capture edge; no other path uses it.

Optional Feature:
- Macro: CART_ROM_CHECKSUM_EN.
- When defined:
  - Adds output checksum [15:0]: running sum mod 2^16 of every byte accepted downstream (each handshake).
  - Cleared to 0 on reset and on each accepted start; holds its final value after done; frozen on abort.
- When undefined: the port and adder are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: reset=1 for 2 cycles → cart_rd_l=1, cart_addr=0, out_valid=0, busy=0; start pulsed during reset has no effect.
- Single sweep, SETTLE_CYCLES=4, START=0x0100, END=0x0103, out_ready=1, cart_data model = addr[7:0]^8'hA5:
  - Four bytes A5,A4,A7,A6 at out_addr 0x0100..0x0103.
  - out_valid first high after edge 4 post-start; bytes spaced 5 cycles apart.
  - done pulses once; busy drops the same cycle done falls.
- Backpressure: hold out_ready=0 for 10 cycles on byte 2 → out_data/out_addr stable, cart_addr unchanged; resumes in order on ready.
- Wrap: START=0xFFFE, END=0x0001 → out_addr sequence FFFE, FFFF, 0000, 0001, then done.
- Abort: assert abort during the second SETTLE → next cycle IDLE, out_valid=0, cart_rd_l=1, no done; a later start restarts at START_ADDR.
- CART_ROM_CHECKSUM_EN defined, bytes 0xFF×3 → checksum = 0x02FD after done; a new start clears it to 0.
